// File: rtl/layer_scheduler.sv
`timescale 1ns/1ps
// layer_scheduler
// Sequences NUM_LAYERS fully-connected layer engines one after another after
// a start pulse.  Each layer is reset (with its enable high), run until it
// reports done, then a dead cycle lets the shared ROM/MultAdder bus settle
// before the next layer is selected.  Each layer's RUN time is bounded by a
// watchdog.  Overflow flags are sampled at each layer's done and ORed.
//
// Ports
//   clk             system clock
//   iRst_n          synchronous active-low reset
//   start           single-cycle pulse, accepted only in IDLE
//   abort           level, cancels a run in RST_L/RUN/NEXT
//   layer_done      per-layer done, only the active index is examined
//   layer_overflow  per-layer overflow, only the active index is examined
//   layer_ena       one-hot-or-zero enable to the layers
//   layer_rst_n     per-layer active-low reset
//   sel             index of the layer owning the shared bus
//   busy            run in progress
//   done            sticky, last layer completed
//   overflow        sticky OR of overflow sampled at each layer's done
//   timeout         sticky, watchdog fired
//   err_layer       index of the layer that timed out
//
// state  | meaning
// IDLE   | waiting for start, all enables low
// RST_L  | active layer enabled and held in reset, watchdog cleared
// RUN    | active layer running, watchdog counting
// NEXT   | dead cycle with all enables low, then next layer or finish
// ERR    | watchdog expired, flag timeout and return to IDLE
module layer_scheduler #(
    parameter int unsigned NUM_LAYERS     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16'd60000
) (
    input  logic                  clk,
    input  logic                  iRst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [NUM_LAYERS-1:0] layer_overflow,
    output logic [NUM_LAYERS-1:0] layer_ena,
    output logic [NUM_LAYERS-1:0] layer_rst_n,
    output logic [2:0]            sel,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  timeout,
    output logic [2:0]            err_layer
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_L,
        S_RUN,
        S_NEXT,
        S_ERR
    } state_t;

    localparam logic [2:0]  LAST_IDX = 3'(NUM_LAYERS - 1);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [15:0]           wd_q, wd_d;
    logic [NUM_LAYERS-1:0] ena_q, ena_d;
    logic [NUM_LAYERS-1:0] rstn_q, rstn_d;
    logic [2:0]            sel_q, sel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  tmo_q, tmo_d;
    logic [2:0]            err_q, err_d;

    // Widen to 8 bits so a 3-bit index never selects outside the vector.
    logic [7:0] done_ext, ovf_ext;
    logic       act_done, act_ovf;

    always_comb begin
        done_ext = 8'(layer_done);
        ovf_ext  = 8'(layer_overflow);
        act_done = done_ext[idx_q];
        act_ovf  = ovf_ext[idx_q];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RST_L;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    err_d   = 3'd0;
                end
            end
            S_RST_L: begin
                wd_d    = 16'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wd_d = wd_q + 16'd1;
                // done is checked first so a layer finishing on the last
                // watchdog cycle still counts as a success
                if (act_done) begin
                    ovf_d   = ovf_q | act_ovf;
                    state_d = S_NEXT;
                end else if (wd_q == WD_LAST) begin
                    err_d   = idx_q;
                    state_d = S_ERR;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_RST_L;
                end
            end
            S_ERR: begin
                tmo_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // abort overrides any done/timeout decision made above
        if (abort && (state_q == S_RST_L || state_q == S_RUN || state_q == S_NEXT)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = done_q;
            ovf_d   = ovf_q;
            tmo_d   = tmo_q;
            err_d   = err_q;
        end
    end

    // Outputs are registered decodes of the next state, so they line up
    // with the state they describe.
    always_comb begin
        ena_d  = '0;
        rstn_d = '1;
        for (int k = 0; k < int'(NUM_LAYERS); k++) begin
            if (idx_d == 3'(k)) begin
                ena_d[k]  = (state_d == S_RST_L) || (state_d == S_RUN);
                rstn_d[k] = (state_d != S_RST_L);
            end
        end
        sel_d = (state_d == S_RST_L) ? idx_d : sel_q;
    end

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            wd_q    <= 16'd0;
            ena_q   <= '0;
            rstn_q  <= '1;
            sel_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            ena_q   <= ena_d;
            rstn_q  <= rstn_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign layer_ena   = ena_q;
    assign layer_rst_n = rstn_q;
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign timeout     = tmo_q;
    assign err_layer   = err_q;

endmodule

// File: tb/tb_layer_scheduler.sv
`timescale 1ns/1ps
// Bench for layer_scheduler: behavioural layer engines with programmable done
// latency and overflow behaviour, and an arithmetic reference that predicts
// run length, final flags and the enable sequence for each run.
module tb_layer_scheduler;

    localparam int NL     = 3;
    localparam int T      = 24;
    localparam int BUDGET = 600;

    logic          clk;
    logic          iRst_n;
    logic          start;
    logic          abort;
    logic [NL-1:0] layer_done;
    logic [NL-1:0] layer_overflow;
    logic [NL-1:0] layer_ena;
    logic [NL-1:0] layer_rst_n;
    logic [2:0]    sel;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          timeout;
    logic [2:0]    err_layer;

    int checks = 0;
    int errors = 0;

    // layer model: lat = done latency after first RUN edge,
    // mode 0 = no overflow, 1 = overflow while enabled, 2 = pulse one cycle before done
    int lat [NL];
    int mode[NL];
    int cnt [NL];
    bit inject;

    // expectations
    int            exp_cyc;
    bit            exp_done, exp_tmo, exp_ovf;
    int            exp_err, exp_sel;
    logic [NL-1:0] exp_seq[$];

    layer_scheduler #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .iRst_n         (iRst_n),
        .start          (start),
        .abort          (abort),
        .layer_done     (layer_done),
        .layer_overflow (layer_overflow),
        .layer_ena      (layer_ena),
        .layer_rst_n    (layer_rst_n),
        .sel            (sel),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .timeout        (timeout),
        .err_layer      (err_layer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (layer_ena[k] && !layer_rst_n[k]) cnt[k] <= 0;
            else if (layer_ena[k] && cnt[k] < 1000000) cnt[k] <= cnt[k] + 1;
        end
    end

    always_comb begin
        layer_done     = '0;
        layer_overflow = '0;
        for (int k = 0; k < NL; k++) begin
            if (layer_ena[k] && layer_rst_n[k]) begin
                layer_done[k] = (cnt[k] == lat[k]);
                case (mode[k])
                    1:       layer_overflow[k] = 1'b1;
                    2:       layer_overflow[k] = (cnt[k] == lat[k] - 1);
                    default: layer_overflow[k] = 1'b0;
                endcase
            end else if (layer_ena[k]) begin
                layer_done[k]     = 1'b0;
                layer_overflow[k] = (mode[k] == 1);
            end else begin
                layer_done[k]     = 1'bx;
                layer_overflow[k] = 1'bx;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ena"},  layer_ena,   0);
        check({tag, "_rstn"}, layer_rst_n, (1 << NL) - 1);
        check({tag, "_sel"},  sel,         0);
        check({tag, "_busy"}, busy,        0);
        check({tag, "_done"}, done,        0);
        check({tag, "_ovf"},  overflow,    0);
        check({tag, "_tmo"},  timeout,     0);
        check({tag, "_err"},  err_layer,   0);
    endtask

    // Each completed layer costs lat+3 cycles; a stalled layer costs T+2
    // cycles from its RST_L to the timeout flag.
    task automatic predict();
        exp_cyc  = 0;
        exp_done = 1'b1;
        exp_tmo  = 1'b0;
        exp_ovf  = 1'b0;
        exp_err  = 0;
        exp_sel  = NL - 1;
        exp_seq  = {};
        for (int k = 0; k < NL; k++) begin
            exp_seq.push_back(NL'(1 << k));
            exp_seq.push_back('0);
            if (lat[k] <= T - 1) begin
                exp_cyc += lat[k] + 3;
                if (mode[k] == 1) exp_ovf = 1'b1;
            end else begin
                exp_cyc += T + 2;
                exp_done = 1'b0;
                exp_tmo  = 1'b1;
                exp_err  = k;
                exp_sel  = k;
                break;
            end
        end
    endtask

    task automatic do_run(input string tag);
        int            n;
        int            sel_bad;
        int            seq_bad;
        logic [NL-1:0] prev;
        logic [NL-1:0] seq[$];
        predict();
        sel_bad = 0;
        seq_bad = 0;
        prev    = '0;
        seq     = {};
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        n = 0;
        forever begin
            if (layer_ena != prev) begin
                seq.push_back(layer_ena);
                prev = layer_ena;
            end
            if (layer_ena != '0 && (sel >= NL || layer_ena != (NL'(1) << sel))) sel_bad++;
            if (done === 1'b1 || timeout === 1'b1 || n >= BUDGET) break;
            // a start in the final cycle of the run must be ignored
            if (n == exp_cyc - 1) start = 1'b1;
            else if (inject)      start = ($urandom_range(0, 3) == 0);
            else                  start = 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, "_cycles"}, n,         exp_cyc);
        check({tag, "_done"},   done,      exp_done);
        check({tag, "_tmo"},    timeout,   exp_tmo);
        check({tag, "_err"},    err_layer, exp_err);
        check({tag, "_ovf"},    overflow,  exp_ovf);
        check({tag, "_busy"},   busy,      0);
        check({tag, "_ena"},    layer_ena, 0);
        check({tag, "_selbad"}, sel_bad,   0);
        check({tag, "_seqlen"}, seq.size(), exp_seq.size());
        for (int i = 0; i < seq.size() && i < exp_seq.size(); i++)
            if (seq[i] !== exp_seq[i]) seq_bad++;
        check({tag, "_seq"}, seq_bad, 0);
        repeat (3) tick();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, done, exp_done);
        check({tag, "_idle_sel"},  sel,  exp_sel);
    endtask

    task automatic wait_layer1(input string tag);
        int n;
        n = 0;
        while (layer_ena !== 3'b010 && n < BUDGET) begin
            tick();
            n++;
        end
        check({tag, "_reach_l1"}, layer_ena, 3'b010);
    endtask

    initial begin
        iRst_n = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        inject = 1'b0;
        for (int k = 0; k < NL; k++) begin
            lat[k]  = 0;
            mode[k] = 0;
        end
        repeat (3) tick();
        check_reset("por");
        iRst_n = 1'b1;
        tick();

        // nominal 10/20/5, done at cycle 44
        lat[0] = 10; lat[1] = 20; lat[2] = 5;
        do_run("nominal");

        mode[1] = 1;
        do_run("ovf_hold");
        mode[1] = 2;
        do_run("ovf_pulse");
        mode[1] = 0;

        // layer 2 stalls
        lat[0] = 3; lat[1] = 4; lat[2] = 1000;
        do_run("timeout");
        lat[2] = T - 1;
        do_run("wd_edge_done");
        lat[2] = T;
        do_run("wd_edge_tmo");

        // abort during layer 1 RUN; layer 0 overflow must be kept
        lat[0] = 10; lat[1] = 20; lat[2] = 5;
        mode[0] = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_layer1("abort");
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ena",  layer_ena, 0);
        check("abort_busy", busy,      0);
        check("abort_done", done,      0);
        check("abort_ovf",  overflow,  1);
        check("abort_tmo",  timeout,   0);
        repeat (4) tick();
        check("abort_idle_ena", layer_ena, 0);
        mode[0] = 0;
        do_run("after_abort");

        // reset in the middle of layer 1
        mode[0] = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_layer1("midrst");
        repeat (3) tick();
        iRst_n = 1'b0;
        tick();
        check_reset("midrst");
        iRst_n = 1'b1;
        tick();
        do_run("after_rst");

        // random runs with stray start pulses
        inject = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NL; k++) begin
                lat[k]  = int'($urandom_range(0, T - 1));
                mode[k] = int'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 3) == 0)
                lat[$urandom_range(0, NL - 1)] = T + int'($urandom_range(0, 5));
            do_run($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Top-level sequencer for the fully-connected inference pipeline. On a start pulse it runs `NUM_LAYERS` layer engines strictly one after another. For each layer it drives that layer's enable and reset, and it steers the shared weight-ROM and MultAdder bus to the active layer through `sel`. It accumulates overflow flags, guards each layer with a watchdog, and reports completion to the display/argmax stage.

## Interface
- `NUM_LAYERS`, 3: number of sequenced layers (1..8); layer 0 runs first.
- `TIMEOUT_CYCLES`, 16'd60000: maximum RUN cycles per layer before timeout (2..65535).
- `clk`  in  1  system clock.
- `iRst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a run when idle.
- `abort`  in  1  level; cancels a run in progress.
- `layer_done`  in  NUM_LAYERS  per-layer done (registered by the layer).
- `layer_overflow`  in  NUM_LAYERS  per-layer overflow; valid only while that layer is enabled.
- `layer_ena`  out  NUM_LAYERS  one-hot or zero enable to the layers.
- `layer_rst_n`  out  NUM_LAYERS  per-layer active-low synchronous reset.
- `sel`  out  3  index of the layer owning the shared ROM/MultAdder bus.
- `busy`  out  1  high from the cycle after an accepted start until the run ends.
- `done`  out  1  sticky; the last layer completed.
- `overflow`  out  1  sticky OR of the sampled overflow of all completed layers.
- `timeout`  out  1  sticky; the watchdog fired.
- `err_layer`  out  3  index of the layer that timed out.

## Operation
- All outputs are registered.
- Reset values:
  - `layer_ena` = 0, `layer_rst_n` = all ones, `sel` = 0, `err_layer` = 0.
  - `busy`, `done`, `overflow`, `timeout` = 0.
  - State IDLE, index `idx` = 0, watchdog counter `wd` = 0.
- States:
  - IDLE: all `layer_ena` low.
    - `start`=1 → RST_L with `idx`=0.
    - On that transition clear `done`, `overflow`, `timeout`, `err_layer` and set `busy`.
  - RST_L: `layer_ena[idx]`=1, `layer_rst_n[idx]`=0, `sel`=`idx`, `wd`=0 → RUN.
    - The reset must be asserted with enable high, because layers ignore reset while disabled.
  - RUN: `layer_ena[idx]`=1, `layer_rst_n[idx]`=1, `wd` increments.
    - `layer_done[idx]`=1 → NEXT; `overflow` |= `layer_overflow[idx]` is sampled this same cycle.
    - Else if `wd` == `TIMEOUT_CYCLES`-1 → ERR with `err_layer`=`idx`.
  - NEXT: `layer_ena` = 0 (one dead cycle so the shared bus settles).
    - If `idx` == `NUM_LAYERS`-1 → IDLE with `done`=1 and `busy`=0.
    - Else `idx`+1 → RST_L.
  - ERR: `layer_ena` = 0, `timeout`=1, `busy`=0 → IDLE.
- Only `layer_done`/`layer_overflow` bits of the active `idx` are examined. Other bits may be X or Z.
- Boundary cases:
  - `start` while busy: ignored.
  - `start` in the same cycle the run ends: ignored; a new `start` is required.
  - `abort`=1 in RST_L, RUN or NEXT → IDLE next cycle.
    - All enables drop, `busy`=0, `done` stays 0, and `overflow` keeps its partial value.
    - `abort` has priority over done and timeout.
  - `layer_done` and watchdog expiry in the same cycle: done wins, no timeout.
  - `iRst_n` low mid-run: all outputs take their reset values at the next edge; the layers are simply disabled.
  - `NUM_LAYERS`=1: NEXT goes directly to IDLE with `done`.

## Timing
- `start` sampled at edge E0 → RST_L outputs visible after E0; the layer samples its reset at E1.
- A layer whose `done` rises L edges after its first RUN edge costs L+3 cycles of scheduler time: RST_L, RUN…, NEXT.
- Total start-to-`done` = Σ(L_k+3) cycles.
- `busy` falls in the same cycle `done` rises.
- Watchdog: `timeout` rises exactly `TIMEOUT_CYCLES`+2 cycles after RST_L of the stalled layer: RST_L, `TIMEOUT_CYCLES` RUN cycles, ERR.
- `sel` changes only on entry to RST_L. It is stable for the whole RUN of that layer and holds its last value in IDLE.

## Test plan
- Nominal run: `NUM_LAYERS`=3, behavioural layers with done latency 10/20/5 and no overflow.
  - `layer_ena` one-hot sequence 001→010→100 with single zero gaps.
  - `sel` 0→1→2; `done`=1 at cycle 44 after `start`; `overflow`=0.
- Overflow: layer 1 drives overflow=1 only while enabled and Z otherwise.
  - `overflow`=1 at end, `done`=1.
  - Repeat with overflow pulsing before done only: `overflow`=0, since it is sampled at done.
- Timeout: `TIMEOUT_CYCLES`=16, layer 2 never asserts done.
  - `timeout`=1 and `err_layer`=2 exactly 18 cycles after layer 2's RST_L; `done`=0, `busy`=0.
  - Done asserted on the final watchdog cycle: no timeout.
- Abort: assert `abort` during layer 1 RUN → next cycle `layer_ena`=0, `busy`=0, `done`=0.
  - A fresh `start` then completes normally from layer 0.
- Start while busy / reset mid-run: extra `start` pulses in RUN leave timing unchanged.
  - `iRst_n`=0 during layer 1 → all outputs at reset values after one edge.
  - Restart then runs to `done`.
